// File: rtl/reg_xfer_sequencer_pkg.sv
// Shared types and bus-mux source codes for the register-transfer sequencer.
// Imported by the interface, the top module and the testbench.
package reg_xfer_pkg;

  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_LDI  = 2'b01,
    OP_SWAP = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    DONE = 3'd4
  } state_e;

  // Bus-mux sources above the register range
  localparam int SEL_IMM  = 16;
  localparam int SEL_TMP  = 17;
  localparam int SEL_ZERO = 18;

endpackage

// File: rtl/reg_xfer_sequencer_if.sv
// Command handshake plus bus-mux / register-file control bundle.
// master = control unit and datapath side, slave = sequencer.
interface reg_xfer_if
  import reg_xfer_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 5
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic                cmd_valid;
  logic                cmd_ready;
  op_e                 cmd_op;
  logic [IDX_W-1:0]    cmd_src;
  logic [IDX_W-1:0]    cmd_dst;
  logic [DATA_W-1:0]   cmd_imm;
  logic [DATA_W-1:0]   bus_data;
  logic [SEL_W-1:0]    bus_sel;
  logic [NUM_REGS-1:0] reg_in;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   tmp_q;

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, bus_data,
    input  cmd_ready, bus_sel, reg_in, imm_q, tmp_q
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, bus_data,
    output cmd_ready, bus_sel, reg_in, imm_q, tmp_q
  );

endinterface

// File: rtl/reg_xfer_sequencer_onehot_dec.sv
// Index to one-hot decoder with enable; drives the register-file load strobes.
module onehot_dec #(
  parameter int IDX_W    = 4,
  parameter int NUM_REGS = 16
) (
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    assign onehot[i] = en && (idx == IDX_W'(i));
  end

endmodule

// File: rtl/reg_xfer_sequencer.sv
// Micro-sequencer that steps MOV/LDI/SWAP/CLR through the shared bus mux.
// All bus/enable outputs decode from registered state and latched fields.
module reg_xfer_sequencer
  import reg_xfer_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 5
) (
  input  logic      clk,
  input  logic      clr,
  reg_xfer_if.slave bus,
  output logic      busy,
  output logic      done
);

  localparam int IDX_W = $clog2(NUM_REGS);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [IDX_W-1:0]    src_q, dst_q;
  logic [DATA_W-1:0]   imm_r, tmp_r;
  logic                live_q;
  logic                accept;
  logic                ld_en;
  logic [IDX_W-1:0]    ld_idx;
  logic [SEL_W-1:0]    sel;

  // live_q keeps cmd_ready low until the first edge after reset release
  assign bus.cmd_ready = (state_q == IDLE) && live_q;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign bus.bus_sel   = sel;
  assign bus.imm_q     = imm_r;
  assign bus.tmp_q     = tmp_r;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      op_q    <= OP_MOV;
      src_q   <= '0;
      dst_q   <= '0;
      imm_r   <= '0;
      tmp_r   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (accept) begin
        op_q  <= bus.cmd_op;
        src_q <= bus.cmd_src;
        dst_q <= bus.cmd_dst;
        if (bus.cmd_op == OP_LDI) imm_r <= bus.cmd_imm;
      end
      if (state_q == T1 && op_q == OP_SWAP) tmp_r <= bus.bus_data;
    end
  end

  always_comb begin
    state_d = state_q;
    sel     = SEL_W'(SEL_ZERO);
    ld_en   = 1'b0;
    ld_idx  = dst_q;
    unique case (state_q)
      IDLE: if (accept) state_d = T1;
      T1: begin
        unique case (op_q)
          OP_MOV:  begin sel = SEL_W'(src_q);    ld_en = 1'b1; end
          OP_LDI:  begin sel = SEL_W'(SEL_IMM);  ld_en = 1'b1; end
          OP_CLR:  begin sel = SEL_W'(SEL_ZERO); ld_en = 1'b1; end
          OP_SWAP: sel = SEL_W'(src_q);
          default: ;
        endcase
        state_d = (op_q == OP_SWAP) ? T2 : DONE;
      end
      T2: begin
        sel     = SEL_W'(dst_q);
        ld_idx  = src_q;
        ld_en   = 1'b1;
        state_d = T3;
      end
      T3: begin
        sel     = SEL_W'(SEL_TMP);
        ld_en   = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  onehot_dec #(
    .IDX_W    (IDX_W),
    .NUM_REGS (NUM_REGS)
  ) u_dec (
    .en     (ld_en),
    .idx    (ld_idx),
    .onehot (bus.reg_in)
  );

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// Scoreboard bench: per-cycle expected bus_sel/reg_in/done queued at issue,
// popped by a monitor; a 16x32 register model is loaded from reg_in/bus_sel.
module tb_reg_xfer_sequencer;
  import reg_xfer_pkg::*;

  typedef struct packed {
    logic [4:0]  sel;
    logic [15:0] rin;
    logic        dn;
  } exp_t;

  logic clk, clr, busy, done;
  int   n_cmp, n_bad;
  exp_t q[$];
  logic [31:0] model [16] = '{default: '0};

  reg_xfer_if #(.DATA_W(32), .NUM_REGS(16), .SEL_W(5)) bus ();

  reg_xfer_sequencer #(.DATA_W(32), .NUM_REGS(16), .SEL_W(5)) dut (
    .clk  (clk),
    .clr  (clr),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // external bus mux
  always_comb begin
    bus.bus_data = '0;
    if (bus.bus_sel < 5'd16)        bus.bus_data = model[bus.bus_sel[3:0]];
    else if (bus.bus_sel == 5'd16)  bus.bus_data = bus.imm_q;
    else if (bus.bus_sel == 5'd17)  bus.bus_data = bus.tmp_q;
  end

  always @(posedge clk)
    for (int k = 0; k < 16; k++)
      if (bus.reg_in[k]) model[k] <= bus.bus_data;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(op_e op, int s, int d);
    logic [15:0] os, od;
    os = 16'h1 << s;
    od = 16'h1 << d;
    case (op)
      OP_MOV:  q.push_back('{sel: 5'(s),  rin: od, dn: 1'b0});
      OP_LDI:  q.push_back('{sel: 5'd16,  rin: od, dn: 1'b0});
      OP_CLR:  q.push_back('{sel: 5'd18,  rin: od, dn: 1'b0});
      default: begin
        q.push_back('{sel: 5'(s),  rin: 16'h0, dn: 1'b0});
        q.push_back('{sel: 5'(d),  rin: os,    dn: 1'b0});
        q.push_back('{sel: 5'd17,  rin: od,    dn: 1'b0});
      end
    endcase
    q.push_back('{sel: 5'd18, rin: 16'h0, dn: 1'b1});
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (clr && busy) begin
        if (q.size() == 0) chk("sb_unexpected_busy", 32'(busy), 32'd0);
        else begin
          e = q.pop_front();
          chk("sb_bus_sel", 32'(bus.bus_sel), 32'(e.sel));
          chk("sb_reg_in",  32'(bus.reg_in),  32'(e.rin));
          chk("sb_done",    32'(done),        32'(e.dn));
        end
      end
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) return;
    end
    chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(op_e op, int s, int d, logic [31:0] imm);
    wait_ready();
    bus.cmd_op    = op;
    bus.cmd_src   = 4'(s);
    bus.cmd_dst   = 4'(d);
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    push_exp(op, s, d);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // cycles from accept edge until cmd_ready is seen again
  task automatic latency(string name, int exp);
    int lat;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus.cmd_ready) break;
    end
    chk(name, 32'(lat), 32'(exp));
  endtask

  task automatic stimulus();
    // reset
    clr = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_MOV;
    bus.cmd_src = '0; bus.cmd_dst = '0; bus.cmd_imm = '0;
    #12;
    chk("rst_reg_in", 32'(bus.reg_in), 32'h0);
    chk("rst_bus_sel", 32'(bus.bus_sel), 32'd18);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
    #10 clr = 1'b1;
    #1 chk("rel_ready_pre_edge", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("rel_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_imm_q", bus.imm_q, 32'h0);
    chk("rst_tmp_q", bus.tmp_q, 32'h0);

    // preload via LDI
    issue(OP_LDI, 0, 3, 32'h0000_00A5);
    chk("ldi_imm_q", bus.imm_q, 32'h0000_00A5);
    issue(OP_LDI, 0, 1, 32'h11);
    issue(OP_LDI, 0, 2, 32'h22);
    issue(OP_LDI, 0, 0, 32'h55);
    wait_ready();
    chk("pre_r0", model[0], 32'h55);
    chk("pre_r3", model[3], 32'hA5);

    // MOV R3 -> R7
    issue(OP_MOV, 3, 7, 32'h0);
    latency("mov_latency", 3);
    chk("mov_r7", model[7], 32'hA5);

    // LDI -> R15
    issue(OP_LDI, 0, 15, 32'hDEAD_BEEF);
    chk("ldi_imm_deadbeef", bus.imm_q, 32'hDEAD_BEEF);
    latency("ldi_latency", 3);
    chk("ldi_r15", model[15], 32'hDEAD_BEEF);

    // SWAP R1, R2
    issue(OP_SWAP, 1, 2, 32'h0);
    latency("swap_latency", 5);
    chk("swap_r1", model[1], 32'h22);
    chk("swap_r2", model[2], 32'h11);
    chk("swap_tmp_q", bus.tmp_q, 32'h11);

    // CLR R0 with a MOV held on cmd_valid while busy
    wait_ready();
    bus.cmd_op = OP_CLR; bus.cmd_dst = 4'd0; bus.cmd_valid = 1'b1;
    push_exp(OP_CLR, 0, 0);
    @(posedge clk);
    #1;
    bus.cmd_op = OP_MOV; bus.cmd_src = 4'd7; bus.cmd_dst = 4'd6;
    bus.cmd_imm = 32'hCAFE_F00D;
    push_exp(OP_MOV, 7, 6);
    @(negedge clk) chk("busy_ready_t1", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk) chk("busy_ready_done", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk) chk("ready_after_clr", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    wait_ready();
    chk("clr_r0", model[0], 32'h0);
    chk("mov_after_busy_r6", model[6], 32'hA5);
    chk("imm_q_untouched", bus.imm_q, 32'hDEAD_BEEF);

    // SWAP with src == dst
    issue(OP_SWAP, 7, 7, 32'h0);
    latency("swap_same_latency", 5);
    chk("swap_same_r7", model[7], 32'hA5);
    chk("swap_same_tmp", bus.tmp_q, 32'hA5);

    // reset during SWAP T2
    issue(OP_SWAP, 1, 2, 32'h0);
    @(posedge clk);
    #2;
    chk("t2_reg_in", 32'(bus.reg_in), 32'h0002);
    clr = 1'b0;
    q.delete();
    #1;
    chk("abort_reg_in", 32'(bus.reg_in), 32'h0);
    chk("abort_bus_sel", 32'(bus.bus_sel), 32'd18);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tmp_q", bus.tmp_q, 32'h0);
    repeat (2) @(posedge clk);
    #2 clr = 1'b1;
    #1 chk("abort_ready_pre_edge", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
    chk("abort_r1", model[1], 32'h22);
    chk("abort_r2", model[2], 32'h11);

    // recovery
    issue(OP_MOV, 15, 4, 32'h0);
    latency("recover_latency", 3);
    chk("recover_r4", model[4], 32'hDEAD_BEEF);
    chk("sb_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
